// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, FSM states,
// lane count and the registered response descriptor.
package dmem_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Everything the response stage needs about the request accepted last cycle.
    typedef struct packed {
        logic       vld;
        logic       err;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } rsp_meta_t;

    // Lane i holds byte offset i (lane 0 = word bits 31:24, big-endian).
    function automatic logic [LANES-1:0] lane_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_en = 4'b0001 << off;
            SZ_HALF: lane_en = 4'b0011 << off;
            default: lane_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// One byte lane of the data memory: synchronous write, registered read.
module dmem_lane_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_bytelane.sv
// Big-endian byte-addressed data memory with valid/ready request, one-cycle
// response and post-reset zero sweep. DMEM_STATS_EN adds access counters.
module data_mem_bytelane
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] load_cnt,
    output logic [15:0] store_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int WA_W = ADDR_W - 2;

    state_t                      st;
    logic [WA_W-1:0]             cnt;
    logic                        ready;
    logic                        acc;
    logic                        err;
    logic                        sweep;
    logic [31:0]                 wd;
    logic [LANES-1:0]            be;
    logic [WA_W-1:0]             ram_addr;
    logic [LANES-1:0]            lane_we;
    logic [LANES-1:0][7:0]       lane_wd;
    logic [LANES-1:0][7:0]       lane_rd;
    rsp_meta_t                   meta;
    logic [7:0]                  bsel;
    logic [15:0]                 hsel;
    logic [31:0]                 rdata;

    assign ready     = (st == READY);
    assign req_ready = ready;
    assign init_done = ready;

    // rst wins over a simultaneous request so nothing is written or answered.
    assign acc   = req_valid & ready & ~rst;
    assign sweep = INIT_ZERO && (st == INIT) && !rst;

    always_comb begin
        err = (req_addr >> ADDR_W) != 32'd0;
        case (req_size)
            SZ_BYTE: ;
            SZ_HALF: if (req_addr[0])          err = 1'b1;
            SZ_WORD: if (req_addr[1:0] != 2'b0) err = 1'b1;
            default: err = 1'b1;
        endcase
    end

    // Replicate store data so every lane sees its byte at the same slice.
    always_comb begin
        case (req_size)
            SZ_BYTE: wd = {4{req_wdata[7:0]}};
            SZ_HALF: wd = {2{req_wdata[15:0]}};
            default: wd = req_wdata;
        endcase
    end

    assign be       = lane_en(req_size, req_addr[1:0]);
    assign ram_addr = sweep ? cnt : req_addr[ADDR_W-1:2];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_we[i] = sweep | (acc & req_we & ~err & be[i]);
        assign lane_wd[i] = sweep ? 8'h00 : wd[31-8*i -: 8];

        dmem_lane_ram #(.AW(WA_W)) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .addr  (ram_addr),
            .wdata (lane_wd[i]),
            .rdata (lane_rd[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= INIT;
            cnt <= '0;
        end else begin
            case (st)
                INIT: begin
                    if (!INIT_ZERO) begin
                        st <= READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '1) st <= READY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
        end else begin
            meta.vld  <= acc;
            meta.err  <= acc & err;
            meta.we   <= req_we;
            meta.size <= req_size;
            meta.uns  <= req_unsigned;
            meta.off  <= req_addr[1:0];
        end
    end

    // Extraction works on the registered lane outputs of the previous accept.
    always_comb begin
        rdata = '0;
        bsel  = lane_rd[meta.off];
        hsel  = {lane_rd[{meta.off[1], 1'b0}], lane_rd[{meta.off[1], 1'b1}]};
        if (meta.vld && !meta.err && !meta.we) begin
            case (meta.size)
                SZ_BYTE: rdata = meta.uns ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
                SZ_HALF: rdata = meta.uns ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
                default: rdata = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
            endcase
        end
    end

    assign rsp_valid = meta.vld;
    assign rsp_err   = meta.err;
    assign rsp_rdata = rdata;

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            err_cnt   <= '0;
        end else if (acc) begin
            if (err) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
            end else if (req_we) begin
                if (store_cnt != 16'hFFFF) store_cnt <= store_cnt + 1'b1;
            end else begin
                if (load_cnt != 16'hFFFF) load_cnt <= load_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Scoreboard bench for data_mem_bytelane (ADDR_W=6): expectations queued at
// drive time, checked when rsp_valid pulses.
module tb_data_mem_bytelane;
    import dmem_pkg::*;

    localparam int AW  = 6;
    localparam int MEM = 1 << AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;
`ifdef DMEM_STATS_EN
    logic [15:0] load_cnt, store_cnt, err_cnt;
`endif

    always #5 clk = ~clk;

    data_mem_bytelane #(.ADDR_W(AW), .INIT_ZERO(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
`ifdef DMEM_STATS_EN
        ,
        .load_cnt     (load_cnt),
        .store_cnt    (store_cnt),
        .err_cnt      (err_cnt)
`endif
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] model [MEM];
    logic       prev_v = 1'b0;
    logic       cur_v  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == SZ_HALF && a[0]) ||
               (sz == SZ_WORD && a[1:0] != 2'b00) || (a >= 32'(MEM));
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int         ia;
        logic [7:0] b;
        logic [15:0] h;
        ia = int'(a[AW-1:0]);
        case (sz)
            SZ_BYTE: begin
                b = model[ia];
                return uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            SZ_HALF: begin
                h = {model[ia], model[ia+1]};
                return uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return {model[ia], model[ia+1], model[ia+2], model[ia+3]};
        endcase
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int ia;
        ia = int'(a[AW-1:0]);
        case (sz)
            SZ_BYTE: model[ia] = wd[7:0];
            SZ_HALF: begin
                model[ia]   = wd[15:8];
                model[ia+1] = wd[7:0];
            end
            default: begin
                model[ia]   = wd[31:24];
                model[ia+1] = wd[23:16];
                model[ia+2] = wd[15:8];
                model[ia+3] = wd[7:0];
            end
        endcase
    endtask

    // Drive one request for exactly one accept edge; caller idles afterwards.
    task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        e.rd  = exp_rd;
        e.err = exp_err;
        sb.push_back(e);
        if (we && !m_err(sz, a)) m_store(sz, a, wd);
        @(posedge clk);
    endtask

    task automatic auto_op(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
        logic        e;
        logic [31:0] rd;
        e  = m_err(sz, a);
        rd = (e || we) ? 32'h0 : m_load(sz, uns, a);
        op(we, sz, uns, a, wd, rd, e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        int n;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk({tag, "_ready"},     32'(req_ready), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 1;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #2;
            if (req_ready !== 1'b1) n++;
        end
        chk({tag, "_init_len"},  32'(n), 32'd16);
        chk({tag, "_init_up"},   32'(init_done), 32'd1);
        for (int i = 0; i < MEM; i++) model[i] = 8'h00;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            prev_v = cur_v;
            cur_v  = rsp_valid;
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rd);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin : stim
        logic [1:0]  sz;
        logic [31:0] a;
        do_reset("por");

        op(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
        op(1'b1, SZ_WORD, 1'b0, 32'h8, 32'h80F0_3344, 32'h0, 1'b0);
        op(1'b0, SZ_BYTE, 1'b0, 32'h8, 32'h0, 32'hFFFF_FF80, 1'b0);
        op(1'b0, SZ_BYTE, 1'b1, 32'h8, 32'h0, 32'h0000_0080, 1'b0);
        op(1'b0, SZ_HALF, 1'b0, 32'h8, 32'h0, 32'hFFFF_80F0, 1'b0);
        op(1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0, 32'h0000_3344, 1'b0);
        op(1'b1, SZ_BYTE, 1'b0, 32'hA, 32'hFFFF_FFAB, 32'h0, 1'b0);
        op(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 32'h80F0_AB44, 1'b0);
        op(1'b1, SZ_HALF, 1'b0, 32'h8, 32'h5555_1234, 32'h0, 1'b0);
        op(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 32'h1234_AB44, 1'b0);
        idle(2);

        op(1'b1, SZ_HALF, 1'b0, 32'h9,   32'hFFFF_FFFF, 32'h0, 1'b1);
        op(1'b0, SZ_WORD, 1'b0, 32'h6,   32'h0,         32'h0, 1'b1);
        op(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0,         32'h0, 1'b1);
        op(1'b1, 2'b11,   1'b0, 32'h8,   32'hFFFF_FFFF, 32'h0, 1'b1);
        op(1'b0, SZ_WORD, 1'b0, 32'h8,   32'h0,         32'h1234_AB44, 1'b0);
        idle(2);

        op(1'b1, SZ_WORD, 1'b0, 32'h4, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0);
        #2;
        chk("b2b_valid", {30'h0, prev_v, cur_v}, 32'h3);
        idle(2);

        for (int k = 0; k < 40; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, MEM + 7));
            if ($urandom_range(0, 3) != 0)
                a = a & ~((sz == SZ_WORD) ? 32'h3 : (sz == SZ_HALF) ? 32'h1 : 32'h0);
            auto_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        idle(2);

        // Accept followed immediately by reset; the sweep must zero old data.
        auto_op(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
        do_reset("rst_after_acc");
        op(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        op(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0);
        idle(2);

        // rst together with a request, then a request held during INIT,
        // then a second reset mid-sweep: none of these may answer.
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SZ_WORD;
        req_addr  = 32'h10;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        do_reset("mid_init");
        op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        idle(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
